m_axil_master: RTL and testbench
================================

Name: m_axil_master

Overview:
- AXI4-Lite initiator: converts single-beat read/write commands from local fabric logic into AXI4-Lite transactions.
- Drives the s_axil_* register slave used for snapshot config/offset, or any AXI4-Lite target.
- Exactly one outstanding transaction; the result is returned on a response port with valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, AXI data width; must be 32 (4 strobe bits).
- ADDR_WIDTH, 10, word-address width; AXI byte address is ADDR_WIDTH+2 bits.

Ports:
- axi_clock  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH+2  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when valid&ready
- rsp_we  out  1  echo of cmd_we
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP as received
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master side; addr ADDR_WIDTH+2, prot 3 (driven 3'b000), data DATA_WIDTH, strb DATA_WIDTH/8, resp 2.

Behaviour:
- Reset (async assert, sync release): all valids 0, bready/rready 0, cmd_ready 1, rsp_* 0, addr/data regs 0, state IDLE.
- States: IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch all cmd fields; cmd_ready→0. we=1 → WRITE with awvalid=wvalid=1 next cycle; we=0 → READ with arvalid=1 next cycle.
- WRITE: awvalid and wvalid are independent. Each drops the cycle after its own ready is sampled high and never re-asserts. Slave may accept AW and W in either order or the same cycle. Once both are done → WAIT_B with bready=1.
- WAIT_B: on bvalid&bready: capture bresp, bready→0, → RESP. rdata result = 0.
- READ: arvalid held until arready; then → WAIT_R with rready=1.
- WAIT_R: on rvalid&rready: capture rdata/rresp, rready→0, → RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready; then → IDLE with cmd_ready=1 the following cycle.
- Min latency with a zero-wait slave: write cmd accept → rsp_valid at +3 cycles; read identical.
- Valid signals never deassert before handshake (AXI rule). Address/data/strobe stable while valid is high.
- No new command accepted until the response is consumed. cmd_valid while busy is ignored, not dropped silently: it is held by the source.
- Non-OKAY responses are passed through unmodified; no retry.
- Reset mid-transaction: immediate return to IDLE, all AXI valids/readies 0. Any in-flight slave response after reset is not expected (slave shares reset).

Optional Feature:
- Macro M_AXIL_ERR_CNT_EN.
- Defined: extra outputs err_cnt (16-bit) and last_err_addr (ADDR_WIDTH+2).
  - err_cnt increments once per completed transaction with resp != 2'b00.
  - err_cnt saturates at 16'hFFFF.
  - last_err_addr holds the address of the latest such transaction.
  - Both clear on reset only.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Write cmd addr 0x004, data 0xDEADBEEF, strb 0xF; slave awready/wready=1 same cycle, bresp=0 → one AW and one W beat with awaddr=0x004, rsp_valid at +3 cycles, rsp_resp=0, rsp_we=1.
- Read addr 0x004 after the above, slave returns 0xDEADBEEF → araddr=0x004, rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Write with wready delayed 5 cycles after awready → awvalid drops after its handshake, wvalid held exactly until wready, a single B accepted, one response.
- Hold rsp_ready=0 for 10 cycles → rsp_* stable, cmd_ready=0 throughout, second cmd_valid ignored until consumed.
- Slave returns rresp=2'b10 → rsp_resp=2'b10. With M_AXIL_ERR_CNT_EN: err_cnt=1, last_err_addr=cmd addr.
- Assert rst_n=0 during WAIT_R → all AXI valids/readies and rsp_valid 0 asynchronously; cmd_ready=1 after release; a new read completes normally.

Source files
------------

// File: rtl/m_axil_master.sv
// m_axil_master: single-outstanding AXI4-Lite initiator fed by a local valid/ready command port.
// Optional error tracking (err_cnt, last_err_addr) is built when M_AXIL_ERR_CNT_EN is defined.
module m_axil_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      axi_clock,
    input  logic                      rst_n,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH+1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_we,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

`ifdef M_AXIL_ERR_CNT_EN
    output logic [15:0]               err_cnt,
    output logic [ADDR_WIDTH+1:0]     last_err_addr,
`endif

    output logic [ADDR_WIDTH+1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    output logic [ADDR_WIDTH+1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
);

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // WRITE  | AW and W channels in flight, each retires on its own handshake
    // WAIT_B | bready high, waiting for write response
    // READ   | arvalid high until arready
    // WAIT_R | rready high, waiting for read data
    // RESP   | rsp_valid high, result held until rsp_ready
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      we_q;
    logic [ADDR_WIDTH+1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                resp_q;
    logic                      aw_done;
    logic                      w_done;
    logic                      aw_fin;
    logic                      w_fin;
    logic                      b_hs;
    logic                      r_hs;

    assign aw_fin = aw_done || (m_axil_awvalid && m_axil_awready);
    assign w_fin  = w_done  || (m_axil_wvalid && m_axil_wready);
    assign b_hs   = m_axil_bvalid && m_axil_bready;
    assign r_hs   = m_axil_rvalid && m_axil_rready;

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_we ? WRITE : READ;
            WRITE:   if (aw_fin && w_fin) state_nxt = WAIT_B;
            WAIT_B:  if (m_axil_bvalid) state_nxt = RESP;
            READ:    if (m_axil_arready) state_nxt = WAIT_R;
            WAIT_R:  if (m_axil_rvalid) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready      = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        rsp_valid      = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            WRITE: begin
                m_axil_awvalid = !aw_done;
                m_axil_wvalid  = !w_done;
            end
            WAIT_B:  m_axil_bready  = 1'b1;
            READ:    m_axil_arvalid = 1'b1;
            WAIT_R:  m_axil_rready  = 1'b1;
            RESP:    rsp_valid      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                we_q    <= cmd_we;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                rdata_q <= '0;
                resp_q  <= '0;
            end
            // per-channel completion flags keep a retired valid from re-asserting
            if (state == WRITE) begin
                if (m_axil_awvalid && m_axil_awready) aw_done <= 1'b1;
                if (m_axil_wvalid && m_axil_wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (b_hs) resp_q <= m_axil_bresp;
            if (r_hs) begin
                rdata_q <= m_axil_rdata;
                resp_q  <= m_axil_rresp;
            end
        end
    end

`ifdef M_AXIL_ERR_CNT_EN
    logic [1:0] done_resp;

    assign done_resp = b_hs ? m_axil_bresp : m_axil_rresp;

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt       <= '0;
            last_err_addr <= '0;
        end else if ((b_hs || r_hs) && done_resp != 2'b00) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            last_err_addr <= addr_q;
        end
    end
`endif

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign rsp_we        = we_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_m_axil_master.sv
// Bench for m_axil_master: memory-backed AXI4-Lite slave with random stalls and a queue-based
// expected-response model; define M_AXIL_ERR_CNT_EN to also check err_cnt / last_err_addr.
`timescale 1ns/1ps
module tb_m_axil_master;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BA = AW + 2;

    logic          axi_clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [BA-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_we;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [BA-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic          bvalid = 1'b0, rvalid = 1'b0;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = '0, rresp = '0;
    logic [31:0]   rdata = '0;
`ifdef M_AXIL_ERR_CNT_EN
    logic [15:0]   err_cnt;
    logic [BA-1:0] last_err_addr;
`endif

    always #5 axi_clock = ~axi_clock;

    m_axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .axi_clock(axi_clock), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
`ifdef M_AXIL_ERR_CNT_EN
        .err_cnt(err_cnt), .last_err_addr(last_err_addr),
`endif
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment rule: the top quarter of the byte address space answers SLVERR.
    function automatic logic [1:0] resp_for(input logic [BA-1:0] a);
        return (a[BA-1:BA-2] == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- slave ----------------
    bit            rand_mode = 0, rr_rand = 0, hold = 0, r_block = 0;
    int            w_gap = 0;
    logic [31:0]   mem [1024];
    bit            aw_have, w_have, ar_have, b_ack, r_ack;
    int            aw_age;
    logic [BA-1:0] s_awaddr, s_araddr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;

    always begin
        @(negedge axi_clock);
        #1;
        if (!rst_n) begin
            aw_have = 0; w_have = 0; ar_have = 0; b_ack = 0; r_ack = 0; aw_age = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        end else begin
            if (b_ack) begin bvalid = 0; aw_have = 0; w_have = 0; b_ack = 0; end
            if (r_ack) begin rvalid = 0; ar_have = 0; r_ack = 0; end
            if (aw_have) aw_age++;
            awready = !aw_have && (rand_mode ? ($urandom % 2 == 1) : 1'b1);
            wready  = !w_have && (rand_mode ? ($urandom % 2 == 1)
                                            : ((w_gap == 0) || (aw_have && aw_age >= w_gap)));
            arready = !ar_have && (rand_mode ? ($urandom % 2 == 1) : 1'b1);
            if (aw_have && w_have && !bvalid && (rand_mode ? ($urandom % 2 == 1) : 1'b1)) begin
                bresp = resp_for(s_awaddr);
                if (bresp == 2'b00)
                    for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) mem[s_awaddr[BA-1:2]][8*i +: 8] = s_wdata[8*i +: 8];
                bvalid = 1;
            end
            if (ar_have && !rvalid && !r_block && (rand_mode ? ($urandom % 2 == 1) : 1'b1)) begin
                rdata  = mem[s_araddr[BA-1:2]];
                rresp  = resp_for(s_araddr);
                rvalid = 1;
            end
        end
        #3;
        if (rst_n) begin
            if (awvalid && awready) begin aw_have = 1; s_awaddr = awaddr; aw_age = 0; end
            if (wvalid && wready) begin w_have = 1; s_wdata = wdata; s_wstrb = wstrb; end
            if (arvalid && arready) begin ar_have = 1; s_araddr = araddr; end
            if (bvalid && bready) b_ack = 1;
            if (rvalid && rready) r_ack = 1;
        end
    end

    always begin
        @(negedge axi_clock);
        #1;
        rsp_ready = hold ? 1'b0 : (rr_rand ? ($urandom % 4 != 0) : 1'b1);
    end

    // ---------------- reference model + compare ----------------
    typedef struct {
        logic          we;
        logic [BA-1:0] addr;
        logic [31:0]   rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t          expq[$];
    logic [31:0]   ref_mem [1024];
    bit            busy, lat_seen;
    int            cyc, acc_cyc, last_lat, rsp_cnt;
    int            aw_beats, w_beats, ar_beats, aw_cyc, w_cyc;
    logic [BA-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_wstrb;
    logic          last_we;
    logic [31:0]   last_rdata;
    logic [1:0]    last_resp;
    int            m_err;
    logic [BA-1:0] m_last;
    logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv, p_rspr, p_rsp_we;
    logic [BA-1:0] p_awaddr, p_araddr;
    logic [31:0]   p_wdata, p_rsp_rdata;
    logic [3:0]    p_wstrb;
    logic [1:0]    p_rsp_resp;

    always begin
        exp_t e;
        @(negedge axi_clock);
        #4;
        cyc++;
        if (!rst_n) begin
            busy = 0; expq.delete(); m_err = 0; m_last = '0;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv, p_rspr} = '0;
        end else begin
            check("cmd_ready", cmd_ready, !busy);
            if (p_awv && !p_awr) begin
                check("awvalid_hold", awvalid, 1);
                check("awaddr_stable", awaddr, p_awaddr);
            end
            if (p_awv && p_awr) check("awvalid_drop", awvalid, 0);
            if (p_wv && !p_wr) begin
                check("wvalid_hold", wvalid, 1);
                check("wdata_stable", {wstrb, wdata}, {p_wstrb, p_wdata});
            end
            if (p_wv && p_wr) check("wvalid_drop", wvalid, 0);
            if (p_arv && !p_arr) begin
                check("arvalid_hold", arvalid, 1);
                check("araddr_stable", araddr, p_araddr);
            end
            if (p_arv && p_arr) check("arvalid_drop", arvalid, 0);
            if (p_rspv && !p_rspr) begin
                check("rsp_valid_hold", rsp_valid, 1);
                check("rsp_stable", {rsp_we, rsp_resp, rsp_rdata}, {p_rsp_we, p_rsp_resp, p_rsp_rdata});
            end
            if (awvalid || arvalid) check("prot", {awprot, arprot}, 6'b0);
            if (rsp_valid) begin
                check("rsp_only_when_busy", busy && expq.size() > 0, 1);
                if (!lat_seen) begin last_lat = cyc - acc_cyc; lat_seen = 1; end
            end
            if (awvalid && awready) begin
                aw_beats++; aw_cyc = cyc;
                check("awaddr", awaddr, cur_addr);
            end
            if (wvalid && wready) begin
                w_beats++; w_cyc = cyc;
                check("wdata", {wstrb, wdata}, {cur_wstrb, cur_wdata});
            end
            if (arvalid && arready) begin
                ar_beats++;
                check("araddr", araddr, cur_addr);
            end
            if (rsp_valid && rsp_ready && expq.size() > 0) begin
                e = expq.pop_front();
                check("rsp_we", rsp_we, e.we);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_resp", rsp_resp, e.resp);
                check("beats", {8'(aw_beats), 8'(w_beats), 8'(ar_beats)},
                      e.we ? 24'h010100 : 24'h000001);
                if (e.resp != 2'b00) begin
                    if (m_err < 65535) m_err++;
                    m_last = e.addr;
                end
`ifdef M_AXIL_ERR_CNT_EN
                check("err_cnt", err_cnt, 16'(m_err));
                check("last_err_addr", last_err_addr, m_last);
`endif
                last_we = rsp_we; last_rdata = rsp_rdata; last_resp = rsp_resp;
                rsp_cnt++;
                busy = 0;
            end
            if (cmd_valid && cmd_ready) begin
                e.we = cmd_we; e.addr = cmd_addr; e.resp = resp_for(cmd_addr);
                if (cmd_we) begin
                    e.rdata = '0;
                    if (e.resp == 2'b00)
                        for (int i = 0; i < 4; i++)
                            if (cmd_wstrb[i]) ref_mem[cmd_addr[BA-1:2]][8*i +: 8] = cmd_wdata[8*i +: 8];
                end else begin
                    e.rdata = ref_mem[cmd_addr[BA-1:2]];
                end
                expq.push_back(e);
                busy = 1; acc_cyc = cyc; lat_seen = 0;
                aw_beats = 0; w_beats = 0; ar_beats = 0;
                cur_addr = cmd_addr; cur_wdata = cmd_wdata; cur_wstrb = cmd_wstrb;
            end
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_rspv = rsp_valid; p_rspr = rsp_ready;
            p_rsp_we = rsp_we; p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [BA-1:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int k;
        @(negedge axi_clock);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        k = 0;
        forever begin
            #4;
            if (cmd_ready || k >= 500) break;
            @(negedge axi_clock);
            k++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(negedge axi_clock);
        cmd_valid = 0; cmd_we = 1'($urandom); cmd_addr = BA'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (rsp_cnt < n && k < 500) begin
            @(negedge axi_clock);
            k++;
        end
        check("rsp_arrived", rsp_cnt >= n, 1);
    endtask

    initial begin
        int nd;
        int k;
        logic [BA-1:0] a;
        nd = 0;
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        repeat (3) @(negedge axi_clock);
        #4;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_handshakes", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        check("rst_rsp", {rsp_we, rsp_resp, rsp_rdata}, '0);
        check("rst_addr", {awaddr, araddr, wdata, wstrb}, '0);
        @(negedge axi_clock);
        rst_n = 1;

        issue(1, 12'h004, 32'hDEADBEEF, 4'hF); nd++; wait_done(nd);
        check("wr_latency", last_lat, 3);
        check("wr_rsp", {last_we, last_resp, last_rdata}, {1'b1, 2'b00, 32'h0});

        issue(0, 12'h004, 32'h0, 4'h0); nd++; wait_done(nd);
        check("rd_latency", last_lat, 3);
        check("rd_rsp", {last_we, last_resp, last_rdata}, {1'b0, 2'b00, 32'hDEADBEEF});

        w_gap = 5;
        issue(1, 12'h008, 32'hA5A5_0F0F, 4'b0101); nd++; wait_done(nd);
        w_gap = 0;
        check("w_after_aw_gap", w_cyc - aw_cyc, 5);
        issue(0, 12'h008, 32'h0, 4'h0); nd++; wait_done(nd);
        check("strobe_merge", last_rdata, 32'h00A5_000F);

        hold = 1;
        issue(1, 12'h010, 32'h1234_5678, 4'hF);
        cmd_valid = 1; cmd_we = 0; cmd_addr = 12'h010;
        for (int i = 0; i < 10; i++) begin
            #4;
            check("held_cmd_ready", cmd_ready, 0);
            @(negedge axi_clock);
        end
        check("held_rsp_valid", rsp_valid, 1);
        hold = 0;
        k = 0;
        forever begin
            #4;
            if (cmd_ready || k >= 100) break;
            @(negedge axi_clock);
            k++;
        end
        check("second_cmd_accept", cmd_ready, 1);
        @(negedge axi_clock);
        cmd_valid = 0;
        nd += 2; wait_done(nd);
        check("second_cmd_rdata", last_rdata, 32'h1234_5678);

        issue(0, 12'hC04, 32'h0, 4'h0); nd++; wait_done(nd);
        check("slverr_resp", last_resp, 2'b10);
`ifdef M_AXIL_ERR_CNT_EN
        check("err_cnt_one", err_cnt, 16'd1);
        check("last_err_addr_c04", last_err_addr, 12'hC04);
`endif

        r_block = 1;
        issue(0, 12'h004, 32'h0, 4'h0);
        k = 0;
        while (!rready && k < 50) begin @(negedge axi_clock); k++; end
        check("in_wait_r", rready, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_outputs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        @(negedge axi_clock);
        @(negedge axi_clock);
        rst_n = 1;
        r_block = 0;
        #4;
        check("post_rst_cmd_ready", cmd_ready, 1);
        issue(0, 12'h004, 32'h0, 4'h0); nd++; wait_done(nd);
        check("post_rst_read", {last_resp, last_rdata}, {2'b00, 32'hDEADBEEF});

        rand_mode = 1; rr_rand = 1;
        for (int i = 0; i < 150; i++) begin
            a = {(($urandom % 6 == 0) ? 2'b11 : 2'b00), 4'b0000, 4'($urandom % 16), 2'b00};
            repeat ($urandom % 3) @(negedge axi_clock);
            issue(1'($urandom % 2), a, $urandom, 4'($urandom));
            nd++;
        end
        wait_done(nd);
        rand_mode = 0; rr_rand = 0;
        repeat (3) @(negedge axi_clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
